elevator_call_panel: RTL and testbench
======================================

Name: elevator_call_panel

Overview:
- Panel-side counterpart of the 3-floor elevator controller.
- Debounces the raw active-low car (FB) and hall (CALL) pushbuttons and latches them as pending requests. Drives the controller's active-low FB/CALL inputs, held low until serviced.
- Decodes the controller's FI (7-seg) and DOOR (6-bit animation) outputs back into floor number and door phase. Clears a floor's requests when the door reaches fully open at that floor.
- Sits between the board pushbuttons/lamps and the elevator controller.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a level change (1..15).
- CNT_W, 4, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_fb_n  in  3  raw car buttons, bit i = floor i+1, active-low, asynchronous
- btn_call_n  in  3  raw hall buttons, active-low, asynchronous
- FI  in  7  controller floor indicator, segments [7:1]
- DOOR  in  6  controller door pattern
- UD  in  1  controller direction (1 = up); passed through to dir_lamp
- FB_n  out  3  to controller FB1..FB3, active-low, registered
- CALL_n  out  3  to controller CALL1..CALL3, active-low, registered
- lamp_fb  out  3  pending car-request lamps, active-high
- lamp_call  out  3  pending hall-request lamps, active-high
- cur_floor  out  2  decoded floor 1..3; 0 = not yet known
- door_state  out  2  0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING
- dir_lamp  out  1  registered UD
- serviced  out  3  one-cycle pulse, floor request cleared
- fi_err  out  1  one-cycle pulse, unrecognised FI code
- door_err  out  1  one-cycle pulse, unrecognised or illegal DOOR step

Behaviour:
- Reset (synchronous): all request latches 0; FB_n = CALL_n = 3'b111; lamps 0; cur_floor 0; door_state CLOSED; dir_lamp 0; pulses 0; synchronizers preset 1; counters 0.
- Synchronisation: each raw button passes a 2-FF synchronizer preset to 1.
- Debounce: a per-button counter counts edges where the synchronized value differs from the debounced value, and clears otherwise.
  - When the count would reach DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
  - A 1-to-0 flip is a press event. A 0-to-1 flip produces no event.
- Latency: raw low first sampled at edge 0 -> press event at edge DEBOUNCE_CYCLES+1 -> latch set and FB_n/CALL_n low after edge DEBOUNCE_CYCLES+2.
- Request latch: set on a press event; held until service. A re-press while pending has no effect.
- FI decode (registered each edge):
  - 0110000 -> 1, 1101101 -> 2, 1111001 -> 3.
  - Any other code -> fi_err pulse; cur_floor holds.
- Door FSM, one step per edge on the sampled DOOR value. Codes: close 111111, open1 110011, open2 100001, open3 000000.
  - CLOSED: open1 -> OPENING; close -> stay.
  - OPENING: open2 stays; open3 -> OPEN; close -> CLOSED (aborted, no service).
  - OPEN: open3 stays; open2/open1 -> CLOSING.
  - CLOSING: open2/open1 stay; close -> CLOSED; open3 -> OPEN (re-open, new service event).
  - Unknown code, or a legal code not listed for the current state -> door_err pulse; state holds.
- Service:
  - Applies on the edge the FSM enters OPEN with cur_floor = f (f != 0).
  - Clears fb[f] and call[f]; serviced[f] pulses in the next cycle.
  - Entry with cur_floor = 0 -> no clear.
- Simultaneous events:
  - A press at floor f in the cycle of service at f is discarded.
  - A press at floor f while door_state = OPEN and cur_floor = f is discarded (door already open there).
  - Presses at other floors set normally.
- FB_n = ~fb_latch and CALL_n = ~call_latch, registered; lamps mirror the latches.
- Reset mid-operation: pending requests are lost; outputs return to reset values the next cycle.

Decomposition:
- Shared package elevator_pkg holds:
  - FI codes DISP1/DISP2/DISP3.
  - DOOR codes CLOSE/OPEN1/OPEN2/OPEN3.
  - door_state encoding.
  - Floor count 3.
- The controller is to be moved onto the same package.
- One sub-module, btn_debounce: synchronizer, counter and press-event output for one button; 6 instances.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, hold btn_fb_n[1] low -> FB_n[1] goes 0 and lamp_fb[1] goes 1 after edge 6; FB_n[0] and FB_n[2] stay 1.
- Glitch btn_call_n[2] low for 3 cycles -> CALL_n stays 3'b111, no lamp.
- FI=1111001, pending call[2], DOOR steps close, open1, open2, open3 -> door_state 0,1,1,2; call[2] stays set. Change FI to 1101101 with DOOR steps close, open1, open2, open3 -> call[2] cleared, serviced=3'b010 for one cycle, CALL_n[1]=1.
- DOOR open1 then close -> CLOSED with no service. DOOR 101010 -> door_err pulse, state holds.
- FI=0000000 -> fi_err pulse, cur_floor unchanged.
- Door OPEN at floor 1; press btn_fb_n[0] and btn_fb_n[2] -> fb[1] ignored, fb[3] latched. Assert reset mid-press -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared display/door codes, door phase encoding and door step rule
package elevator_pkg;
  localparam int FLOORS = 3;
  localparam logic [6:0] DISP1 = 7'b0110000;
  localparam logic [6:0] DISP2 = 7'b1101101;
  localparam logic [6:0] DISP3 = 7'b1111001;
  localparam logic [5:0] D_CLOSE = 6'b111111;
  localparam logic [5:0] D_OPEN1 = 6'b110011;
  localparam logic [5:0] D_OPEN2 = 6'b100001;
  localparam logic [5:0] D_OPEN3 = 6'b000000;
  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } door_e;
  typedef struct packed {
    logic  err;
    door_e nxt;
  } door_step_t;
  function automatic door_step_t door_step(door_e s, logic [5:0] d);
    door_step_t r;
    r.err = 1'b0;
    r.nxt = s;
    case (s)
      ST_CLOSED:
        if (d == D_OPEN1) r.nxt = ST_OPENING;
        else r.err = d != D_CLOSE;
      ST_OPENING:
        if (d == D_OPEN3) r.nxt = ST_OPEN;
        else if (d == D_CLOSE) r.nxt = ST_CLOSED;
        else r.err = d != D_OPEN2;
      ST_OPEN:
        if (d == D_OPEN1 || d == D_OPEN2) r.nxt = ST_CLOSING;
        else r.err = d != D_OPEN3;
      ST_CLOSING:
        if (d == D_CLOSE) r.nxt = ST_CLOSED;
        else if (d == D_OPEN3) r.nxt = ST_OPEN;
        else r.err = !(d == D_OPEN1 || d == D_OPEN2);
    endcase
    return r;
  endfunction
endpackage

// File: rtl/elevator_call_panel_btn_debounce.sv
// btn_debounce: synchronizes and debounces one active-low button, pulsing press on release-to-pressed
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  logic r_s1, r_s2, r_deb, r_press;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic w_diff, w_flip;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_diff = r_s2 != r_deb;
  assign w_flip = w_diff && (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES));
  assign press = r_press;
  // two-flop synchronizer, run-length counter and debounced level with press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_deb <= 1'b1;
      r_cnt <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1 <= btn_n;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_flip) ? w_cnt_inc : '0;
      r_deb <= w_flip ? r_s2 : r_deb;
      r_press <= w_flip && !r_s2;
    end
  end
endmodule

// File: rtl/elevator_call_panel.sv
// elevator_call_panel: latches debounced car/hall requests and clears them when the door opens at that floor
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_fb_n,
  input  logic [2:0] btn_call_n,
  input  logic [7:1] FI,
  input  logic [5:0] DOOR,
  input  logic       UD,
  output logic [2:0] FB_n,
  output logic [2:0] CALL_n,
  output logic [2:0] lamp_fb,
  output logic [2:0] lamp_call,
  output logic [1:0] cur_floor,
  output logic [1:0] door_state,
  output logic       dir_lamp,
  output logic [2:0] serviced,
  output logic       fi_err,
  output logic       door_err
);
  logic [2:0] w_press_fb, w_press_call;
  logic [2:0] r_fb, r_call, r_fb_n, r_call_n, r_svc;
  logic [1:0] r_floor;
  door_e r_door;
  logic r_dir, r_fi_err, r_door_err;
  door_step_t w_step;
  logic [2:0] w_here, w_svc, w_block, w_fb_nxt, w_call_nxt;
  logic [1:0] w_fi_floor;
  genvar i;
  for (i = 0; i < FLOORS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_fb (
      .clk(clk), .reset(reset), .btn_n(btn_fb_n[i]), .press(w_press_fb[i]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_call (
      .clk(clk), .reset(reset), .btn_n(btn_call_n[i]), .press(w_press_call[i]));
  end
  assign w_step = door_step(r_door, DOOR);
  // a floor is serviced on entry to OPEN; presses there are dropped while serviced or already open
  always_comb begin
    w_here = (r_floor == 2'd0) ? 3'b000 : 3'b001 << (r_floor - 2'd1);
    w_svc = (w_step.nxt == ST_OPEN && r_door != ST_OPEN) ? w_here : 3'b000;
    w_block = w_svc | ((r_door == ST_OPEN) ? w_here : 3'b000);
    w_fb_nxt = (r_fb | (w_press_fb & ~w_block)) & ~w_svc;
    w_call_nxt = (r_call | (w_press_call & ~w_block)) & ~w_svc;
    w_fi_floor = (FI == DISP1) ? 2'd1 : (FI == DISP2) ? 2'd2 : (FI == DISP3) ? 2'd3 : 2'd0;
  end
  // request latches, decoded floor, door phase and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fb <= 3'b000;
      r_call <= 3'b000;
      r_fb_n <= 3'b111;
      r_call_n <= 3'b111;
      r_floor <= 2'd0;
      r_door <= ST_CLOSED;
      r_dir <= 1'b0;
      r_svc <= 3'b000;
      r_fi_err <= 1'b0;
      r_door_err <= 1'b0;
    end else begin
      r_fb <= w_fb_nxt;
      r_call <= w_call_nxt;
      r_fb_n <= ~w_fb_nxt;
      r_call_n <= ~w_call_nxt;
      r_floor <= (w_fi_floor == 2'd0) ? r_floor : w_fi_floor;
      r_fi_err <= w_fi_floor == 2'd0;
      r_door <= w_step.nxt;
      r_door_err <= w_step.err;
      r_svc <= w_svc;
      r_dir <= UD;
    end
  end
  assign FB_n = r_fb_n;
  assign CALL_n = r_call_n;
  assign lamp_fb = r_fb;
  assign lamp_call = r_call;
  assign cur_floor = r_floor;
  assign door_state = r_door;
  assign dir_lamp = r_dir;
  assign serviced = r_svc;
  assign fi_err = r_fi_err;
  assign door_err = r_door_err;
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: directed and random stimulus checked against a behavioural panel model
module tb_elevator_call_panel;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] btn_fb_n = 3'b111, btn_call_n = 3'b111;
  logic [7:1] FI = 7'b1111001;
  logic [5:0] DOOR = 6'b111111;
  logic UD = 1'b0;
  logic [2:0] FB_n, CALL_n, lamp_fb, lamp_call, serviced;
  logic [1:0] cur_floor, door_state;
  logic dir_lamp, fi_err, door_err;
  int checks = 0, failures = 0;

  elevator_call_panel #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .btn_fb_n(btn_fb_n), .btn_call_n(btn_call_n),
    .FI(FI), .DOOR(DOOR), .UD(UD), .FB_n(FB_n), .CALL_n(CALL_n),
    .lamp_fb(lamp_fb), .lamp_call(lamp_call), .cur_floor(cur_floor),
    .door_state(door_state), .dir_lamp(dir_lamp), .serviced(serviced),
    .fi_err(fi_err), .door_err(door_err));

  always #5 clk = ~clk;

  // model state
  bit [2:0] m_fb, m_call, m_svc;
  bit m_deb [6];
  bit m_press [6];
  int m_last [6];
  bit raw_h [6][4096];
  int m_floor, m_door, e;
  bit m_dir, m_fi_err, m_door_err;
  // next door phase by [phase][opening level]; -1 marks an illegal step
  int tbl [4][4] = '{'{0, 1, -1, -1}, '{0, -1, 1, 2}, '{-1, 3, 3, 2}, '{0, 3, 3, 2}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl_of(logic [5:0] d);
    case (d)
      6'b111111: return 0;
      6'b110011: return 1;
      6'b100001: return 2;
      6'b000000: return 3;
      default:   return -1;
    endcase
  endfunction

  function automatic logic [5:0] code_of(int l);
    case (l)
      0: return 6'b111111;
      1: return 6'b110011;
      2: return 6'b100001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int floor_of(logic [6:0] f);
    case (f)
      7'b0110000: return 1;
      7'b1101101: return 2;
      7'b1111001: return 3;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [6:0] fi_code(int f);
    case (f)
      1: return 7'b0110000;
      2: return 7'b1101101;
      default: return 7'b1111001;
    endcase
  endfunction

  function automatic bit raw_at(int b, int k);
    return (k < 0) ? 1'b1 : raw_h[b][k];
  endfunction

  task automatic model_step();
    int lvl, nxt, fl;
    bit [2:0] here, blk, pfb, pcall;
    bit flip;
    if (reset) begin
      m_fb = 0; m_call = 0; m_svc = 0; m_floor = 0; m_door = 0; m_dir = 0;
      m_fi_err = 0; m_door_err = 0; e = 0;
      for (int b = 0; b < 6; b++) begin
        m_deb[b] = 1; m_press[b] = 0; m_last[b] = -1;
      end
      return;
    end
    lvl = lvl_of(DOOR);
    nxt = (lvl < 0) ? -1 : tbl[m_door][lvl];
    here = (m_floor == 0) ? 3'b000 : 3'(1 << (m_floor - 1));
    m_svc = (nxt == 2 && m_door != 2) ? here : 3'b000;
    blk = m_svc | ((m_door == 2) ? here : 3'b000);
    pfb = {m_press[2], m_press[1], m_press[0]};
    pcall = {m_press[5], m_press[4], m_press[3]};
    m_fb = (m_fb | (pfb & ~blk)) & ~m_svc;
    m_call = (m_call | (pcall & ~blk)) & ~m_svc;
    m_door_err = nxt < 0;
    if (nxt >= 0) m_door = nxt;
    fl = floor_of(FI);
    m_fi_err = fl == 0;
    if (fl != 0) m_floor = fl;
    m_dir = UD;
    for (int b = 0; b < 6; b++) begin
      raw_h[b][e] = (b < 3) ? btn_fb_n[b] : btn_call_n[b-3];
      // level accepted once the last D synchronized samples since the previous flip all disagree
      flip = 1;
      for (int j = 0; j < D; j++)
        if (e - j <= m_last[b] || raw_at(b, e - j - 2) == m_deb[b]) flip = 0;
      if (flip) begin
        m_deb[b] = !m_deb[b];
        m_last[b] = e;
      end
      m_press[b] = flip && !m_deb[b];
    end
    if (e < 4095) e++;
  endtask

  task automatic check_all();
    logic [2:0] efb, ecall;
    efb = ~m_fb;
    ecall = ~m_call;
    chk("FB_n", FB_n, efb);
    chk("CALL_n", CALL_n, ecall);
    chk("lamp_fb", lamp_fb, m_fb);
    chk("lamp_call", lamp_call, m_call);
    chk("cur_floor", cur_floor, m_floor);
    chk("door_state", door_state, m_door);
    chk("dir_lamp", dir_lamp, m_dir);
    chk("serviced", serviced, m_svc);
    chk("fi_err", fi_err, m_fi_err);
    chk("door_err", door_err, m_door_err);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic door_seq(input int a, input int b2, input int c, input int d);
    DOOR = code_of(a); cyc();
    DOOR = code_of(b2); cyc();
    DOOR = code_of(c); cyc();
    DOOR = code_of(d); cyc();
  endtask

  initial begin
    int hold [6];
    bit lv [6];
    int dl, r;
    cyc();
    chk("rst_FB_n", FB_n, 3'b111);
    chk("rst_floor", cur_floor, 2'd0);
    chk("rst_door", door_state, 2'd0);
    reset = 0;
    btn_fb_n = 3'b101;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("deb_wait_FB_n", FB_n, 3'b111);
    end
    cyc();
    chk("deb_FB_n", FB_n, 3'b101);
    chk("deb_lamp_fb", lamp_fb, 3'b010);
    btn_fb_n = 3'b111;
    btn_call_n = 3'b011;
    repeat (3) cyc();
    btn_call_n = 3'b111;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("glitch_CALL_n", CALL_n, 3'b111);
    end
    btn_call_n = 3'b101;
    repeat (8) cyc();
    btn_call_n = 3'b111;
    repeat (6) cyc();
    chk("call2_lamp", lamp_call, 3'b010);
    DOOR = code_of(0); cyc(); chk("ds_close", door_state, 2'd0);
    DOOR = code_of(1); cyc(); chk("ds_open1", door_state, 2'd1);
    DOOR = code_of(2); cyc(); chk("ds_open2", door_state, 2'd1);
    DOOR = code_of(3); cyc(); chk("ds_open3", door_state, 2'd2);
    chk("f3_keep_call2", lamp_call, 3'b010);
    DOOR = code_of(2); cyc();
    DOOR = code_of(0); cyc();
    FI = fi_code(2); cyc();
    door_seq(0, 1, 2, 3);
    chk("svc2_pulse", serviced, 3'b010);
    chk("svc2_CALL_n", CALL_n, 3'b111);
    cyc();
    chk("svc2_end", serviced, 3'b000);
    DOOR = code_of(2); cyc();
    DOOR = code_of(0); cyc();
    FI = fi_code(1); cyc();
    DOOR = code_of(1); cyc();
    DOOR = code_of(2); cyc();
    DOOR = code_of(3); cyc();
    btn_fb_n = 3'b010;
    repeat (8) cyc();
    btn_fb_n = 3'b111;
    repeat (2) cyc();
    chk("open_press_lamp", lamp_fb, 3'b100);
    DOOR = 6'b101010; cyc();
    chk("derr_pulse", door_err, 1'b1);
    chk("derr_hold", door_state, 2'd2);
    DOOR = code_of(3); cyc();
    chk("derr_end", door_err, 1'b0);
    FI = 7'b0000000; cyc();
    chk("fierr_pulse", fi_err, 1'b1);
    chk("fierr_hold", cur_floor, 2'd1);
    FI = fi_code(3); cyc();
    DOOR = code_of(2); cyc();
    DOOR = code_of(0); cyc();
    DOOR = code_of(1); cyc();
    DOOR = code_of(0); cyc();
    chk("abort_state", door_state, 2'd0);
    chk("abort_lamp", lamp_fb, 3'b100);
    btn_call_n = 3'b110;
    repeat (3) cyc();
    reset = 1; cyc();
    chk("midrst_lamp_fb", lamp_fb, 3'b000);
    chk("midrst_CALL_n", CALL_n, 3'b111);
    reset = 0;
    btn_call_n = 3'b111;
    dl = 0;
    for (int b = 0; b < 6; b++) begin hold[b] = 0; lv[b] = 1; end
    for (int t = 0; t < 3000; t++) begin
      reset = $urandom_range(0, 199) == 0;
      for (int b = 0; b < 6; b++) begin
        if (hold[b] == 0) begin
          lv[b] = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 12);
        end else hold[b]--;
      end
      btn_fb_n = {lv[2], lv[1], lv[0]};
      btn_call_n = {lv[5], lv[4], lv[3]};
      r = $urandom_range(0, 39);
      if (r == 0) FI = 7'($urandom);
      else if (r < 4) FI = fi_code($urandom_range(1, 3));
      r = $urandom_range(0, 29);
      if (r == 0) DOOR = 6'($urandom);
      else begin
        if (r < 10) begin
          dl = dl + ($urandom_range(0, 1) == 1 ? 1 : -1);
          dl = (dl < 0) ? 0 : (dl > 3) ? 3 : dl;
        end
        DOOR = code_of(dl);
      end
      UD = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
